// File: rtl/data_mem_responder_if.sv
// Processor RAM bus and host byte-stream bundle
// seen by data_mem_responder.
interface data_mem_responder_if;
  logic [15:0] RAM_ADDRESS;
  logic [15:0] DATA_BUS_in;
  logic [15:0] DATA_BUS_out;
  logic        M_Write;
  logic        RAM_en;
  logic        End_of_process;
  logic        cpu_run;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        frame_done;
  logic        addr_err;

  modport master (
    output RAM_ADDRESS, DATA_BUS_in,
    output M_Write, RAM_en,
    output End_of_process,
    output rx_data, rx_valid, tx_ready,
    input  DATA_BUS_out, cpu_run,
    input  tx_data, tx_valid,
    input  frame_done, addr_err
  );

  modport slave (
    input  RAM_ADDRESS, DATA_BUS_in,
    input  M_Write, RAM_en,
    input  End_of_process,
    input  rx_data, rx_valid, tx_ready,
    output DATA_BUS_out, cpu_run,
    output tx_data, tx_valid,
    output frame_done, addr_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Image buffer: host load, CPU access, host dump.
// Optional DMR_ADDR_CHECK_EN flags out-of-range CPU accesses.
module data_mem_responder #(
  parameter int DEPTH     = 4096,
  parameter int IMG_WORDS = 4096
) (
  input  logic clk,
  input  logic rst_n,
  data_mem_responder_if.slave bus
);
  localparam int AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST =
    AW'(IMG_WORDS - 1);

  typedef enum logic [1:0] {
    LOAD, RUN, DUMP, IDLE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] load_ptr_q, load_ptr_d;
  logic [AW-1:0] dump_ptr_q, dump_ptr_d;
  logic [15:0]   dout_q, dout_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          cpu_run_q, cpu_run_d;
  logic          frame_done_q, frame_done_d;
  logic          prime_q, prime_d;
  logic          err_q, err_d;

  logic [15:0]   mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr, raddr;
  logic [15:0]   wdata, rword;
  logic [AW-1:0] cpu_addr;
  logic          in_range;
  logic          accept;
  logic          unused_addr;

  assign cpu_addr    = bus.RAM_ADDRESS[AW-1:0];
  assign unused_addr = ^bus.RAM_ADDRESS;
  assign accept      = tx_valid_q & bus.tx_ready;
  assign rword       = mem[raddr];

`ifdef DMR_ADDR_CHECK_EN
  assign in_range =
    {1'b0, bus.RAM_ADDRESS} < 17'(DEPTH);
`else
  assign in_range = 1'b1;
`endif

  function automatic logic [7:0] sat8(
    input logic [15:0] w
  );
    return (|w[15:8]) ? 8'hFF : w[7:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    dump_ptr_d   = dump_ptr_q;
    dout_d       = dout_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    frame_done_d = 1'b0;
    prime_d      = 1'b0;
    err_d        = err_q;
    we           = 1'b0;
    waddr        = load_ptr_q;
    wdata        = {8'h00, bus.rx_data};
    raddr        = dump_ptr_q;
    unique case (state_q)
      LOAD: begin
        if (bus.rx_valid) begin
          we = 1'b1;
          if (load_ptr_q == LAST) begin
            state_d    = RUN;
            load_ptr_d = '0;
          end else begin
            load_ptr_d = load_ptr_q + 1'b1;
          end
        end
      end
      IDLE: begin
        if (bus.rx_valid) begin
          we    = 1'b1;
          waddr = '0;
          err_d = 1'b0;
          if (LAST == '0) begin
            state_d    = RUN;
            load_ptr_d = '0;
          end else begin
            state_d    = LOAD;
            load_ptr_d = AW'(1);
          end
        end
      end
      RUN: begin
        raddr = cpu_addr;
        waddr = cpu_addr;
        wdata = bus.DATA_BUS_in;
        if (bus.RAM_en) begin
          if (!in_range) err_d = 1'b1;
          if (bus.M_Write) we = in_range;
          else dout_d = in_range ? rword : '0;
        end
        if (bus.End_of_process) begin
          state_d    = DUMP;
          dump_ptr_d = '0;
        end
      end
      DUMP: begin
        prime_d = 1'b1;
        if (accept) begin
          if (dump_ptr_q == LAST) begin
            tx_valid_d   = 1'b0;
            frame_done_d = 1'b1;
            state_d      = IDLE;
            dump_ptr_d   = '0;
          end else begin
            // prefetch the next word on accept
            raddr      = dump_ptr_q + 1'b1;
            dump_ptr_d = dump_ptr_q + 1'b1;
            tx_data_d  = sat8(rword);
          end
        end else if (prime_q && !tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = sat8(rword);
        end
      end
    endcase
    cpu_run_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      load_ptr_q   <= '0;
      dump_ptr_q   <= '0;
      dout_q       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      cpu_run_q    <= 1'b0;
      frame_done_q <= 1'b0;
      prime_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      dump_ptr_q   <= dump_ptr_d;
      dout_q       <= dout_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      cpu_run_q    <= cpu_run_d;
      frame_done_q <= frame_done_d;
      prime_q      <= prime_d;
      err_q        <= err_d;
    end
  end

  assign bus.DATA_BUS_out = dout_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_valid     = tx_valid_q;
  assign bus.cpu_run      = cpu_run_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.addr_err     = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder:
// load, readback, dump, back-pressure, reset.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  int   vec  = 0;
  int   errs = 0;
  logic [7:0] exp1 [16];

  data_mem_responder_if bus();

  data_mem_responder #(
    .DEPTH(4096),
    .IMG_WORDS(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(
    input string tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic load_frame(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = base + 8'(i);
      tick();
      if (i == 14)
        chk("cpu_run_pre", 16'(bus.cpu_run), 16'h0);
      if (i == 15)
        chk("cpu_run_rise", 16'(bus.cpu_run), 16'h1);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic cpu_rd(
    input logic [15:0] a,
    input logic [15:0] exp,
    input string tag
  );
    bus.RAM_en      = 1'b1;
    bus.M_Write     = 1'b0;
    bus.RAM_ADDRESS = a;
    tick();
    bus.RAM_en = 1'b0;
    chk(tag, bus.DATA_BUS_out, exp);
  endtask

  task automatic cpu_wr(
    input logic [15:0] a,
    input logic [15:0] d
  );
    bus.RAM_en      = 1'b1;
    bus.M_Write     = 1'b1;
    bus.RAM_ADDRESS = a;
    bus.DATA_BUS_in = d;
    tick();
    bus.RAM_en  = 1'b0;
    bus.M_Write = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!bus.tx_valid && n < budget) begin
      tick();
      n++;
    end
    chk("tx_valid_wait", 16'(bus.tx_valid), 16'h1);
  endtask

  initial begin
    int   n;
    int   cyc;
    int   g;
    logic stall;
    logic rdy;
    logic fd_seen;
    logic [7:0] held;

    rst_n = 1'b0;
    bus.RAM_ADDRESS    = '0;
    bus.DATA_BUS_in    = '0;
    bus.M_Write        = 1'b0;
    bus.RAM_en         = 1'b0;
    bus.End_of_process = 1'b0;
    bus.rx_data        = '0;
    bus.rx_valid       = 1'b0;
    bus.tx_ready       = 1'b0;
    repeat (2) tick();
    chk("rst_dout", bus.DATA_BUS_out, 16'h0);
    chk("rst_txd", 16'(bus.tx_data), 16'h0);
    chk("rst_txv", 16'(bus.tx_valid), 16'h0);
    chk("rst_run", 16'(bus.cpu_run), 16'h0);
    chk("rst_fd", 16'(bus.frame_done), 16'h0);
    chk("rst_err", 16'(bus.addr_err), 16'h0);
    rst_n = 1'b1;

    load_frame(8'h10);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h77;
    tick();
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 16; i++)
      cpu_rd(16'(i), 16'h0010 + 16'(i), "readback");
    tick();
    chk("dout_hold", bus.DATA_BUS_out, 16'h001F);

    cpu_wr(16'd3, 16'h0080);
    cpu_rd(16'd3, 16'h0080, "raw_next");
    cpu_wr(16'd4, 16'h0123);
    cpu_wr(16'h1000, 16'hBEEF);
`ifdef DMR_ADDR_CHECK_EN
    chk("oor_err", 16'(bus.addr_err), 16'h1);
    cpu_rd(16'h1000, 16'h0000, "oor_rd");
    cpu_rd(16'h0000, 16'h0010, "oor_mem0");
`else
    chk("wrap_err", 16'(bus.addr_err), 16'h0);
    cpu_rd(16'h0000, 16'hBEEF, "wrap_mem0");
`endif

    for (int i = 0; i < 16; i++)
      exp1[i] = 8'h10 + 8'(i);
    exp1[3] = 8'h80;
    exp1[4] = 8'hFF;
`ifndef DMR_ADDR_CHECK_EN
    exp1[0] = 8'hFF;
`endif

    bus.RAM_en         = 1'b1;
    bus.M_Write        = 1'b0;
    bus.RAM_ADDRESS    = 16'd5;
    bus.End_of_process = 1'b1;
    tick();
    bus.RAM_en         = 1'b0;
    bus.End_of_process = 1'b0;
    bus.tx_ready       = 1'b1;
    chk("simul_rd", bus.DATA_BUS_out, 16'h0015);
    chk("simul_run", 16'(bus.cpu_run), 16'h0);
    chk("dump_lat0", 16'(bus.tx_valid), 16'h0);
    tick();
    chk("dump_lat1", 16'(bus.tx_valid), 16'h0);
    tick();
    chk("dump_lat2", 16'(bus.tx_valid), 16'h1);
    for (int k = 0; k < 16; k++) begin
      chk("dump_byte", 16'(bus.tx_data), 16'(exp1[k]));
      chk("dump_fd_lo", 16'(bus.frame_done), 16'h0);
      tick();
    end
    chk("dump_fd_hi", 16'(bus.frame_done), 16'h1);
    chk("dump_end_v", 16'(bus.tx_valid), 16'h0);
    tick();
    chk("dump_fd_pulse", 16'(bus.frame_done), 16'h0);
    bus.tx_ready = 1'b0;
    cpu_rd(16'd1, 16'h0015, "idle_rd_ignored");

    load_frame(8'h20);
    chk("err_clear", 16'(bus.addr_err), 16'h0);
    bus.End_of_process = 1'b1;
    tick();
    bus.End_of_process = 1'b0;
    n = 0;
    cyc = 0;
    stall = 1'b0;
    fd_seen = 1'b0;
    held = '0;
    while (!fd_seen && cyc < 200) begin
      if (stall) begin
        chk("bp_hold", 16'(bus.tx_data), 16'(held));
        chk("bp_valid", 16'(bus.tx_valid), 16'h1);
      end
      rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.tx_ready = rdy;
      stall = bus.tx_valid && !rdy;
      held  = bus.tx_data;
      if (bus.tx_valid && rdy) begin
        chk("bp_byte", 16'(bus.tx_data),
            16'h0020 + 16'(n));
        n++;
      end
      tick();
      cyc++;
      if (bus.frame_done) fd_seen = 1'b1;
    end
    chk("bp_count", 16'(n), 16'd16);
    chk("bp_fd", 16'(fd_seen), 16'h1);
    bus.tx_ready = 1'b0;

    load_frame(8'h30);
    bus.End_of_process = 1'b1;
    tick();
    bus.End_of_process = 1'b0;
    bus.tx_ready = 1'b1;
    wait_valid(8);
    g = 0;
    while (bus.tx_data != 8'h37 && g < 20) begin
      tick();
      g++;
    end
    chk("rst_at_b7", 16'(bus.tx_data), 16'h0037);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txv", 16'(bus.tx_valid), 16'h0);
    chk("mid_rst_run", 16'(bus.cpu_run), 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.tx_ready = 1'b0;
    load_frame(8'h40);
    cpu_rd(16'd0, 16'h0040, "reload_0");
    cpu_rd(16'd7, 16'h0047, "reload_7");
    cpu_rd(16'd15, 16'h004F, "reload_15");

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end
endmodule
